// File: rtl/fwft_fifo_unpacker.sv
// fwft_fifo_unpacker: drains a first-word-fall-through FIFO of wide words and
// replays each word as `ratio` narrow beats on a valid/ready stream, LSB first.
// An optional frame counter flags the final beat of every frame with out_last.
module fwft_fifo_unpacker #(
  parameter int unsigned out_width       = 8,
  parameter int unsigned ratio           = 4,
  parameter int unsigned in_width        = 32,
  parameter int unsigned words_per_frame = 0,
  parameter int unsigned cntw            = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clken,
  input  logic                 fifo_empty,
  output logic                 fifo_read_en,
  input  logic [in_width-1:0]  fifo_read_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [out_width-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int unsigned beat_w   = (ratio > 1) ? $clog2(ratio) : 1;
  localparam int unsigned last_idx = ratio - 1;

  // Reject inconsistent configurations at elaboration time.
  if ((in_width != out_width * ratio) || (ratio < 1) ||
      ((cntw < 32) && (words_per_frame > (32'd1 << cntw)))) begin : g_cfg_check
    $fatal(1, "fwft_fifo_unpacker: bad parameters (in_width must equal out_width*ratio)");
  end

  logic [in_width-1:0] hold_q;
  logic                valid_q;
  logic [beat_w-1:0]   beat_q;

  logic last_beat;
  logic beat_fire;

  assign last_beat = (beat_q == beat_w'(last_idx));
  assign beat_fire = clken & valid_q & out_ready;

  // Refill the holding register when it is empty or its last beat leaves now.
  assign fifo_read_en = clken & ~reset & ~fifo_empty & (~valid_q | (beat_fire & last_beat));

  assign out_valid = valid_q;
  assign busy      = valid_q | ~fifo_empty;

  // Beat selection out of the held word.
  if (ratio == 1) begin : g_single
    assign out_data = hold_q[out_width-1:0];
  end else begin : g_multi
    logic [ratio-1:0][out_width-1:0] beats;
    assign beats    = hold_q;
    assign out_data = beats[beat_q];
  end

  // Holding register, valid flag and beat index; a FIFO load restarts at beat 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else if (clken) begin
      if (fifo_read_en) begin
        hold_q  <= fifo_read_data;
        valid_q <= 1'b1;
        beat_q  <= '0;
      end else if (beat_fire) begin
        if (last_beat) begin
          valid_q <= 1'b0;
          beat_q  <= '0;
        end else begin
          beat_q <= beat_q + 1'b1;
        end
      end
    end
  end

  // Frame boundary tracking, present only when frames are enabled.
  if (words_per_frame > 0) begin : g_frame
    logic [cntw-1:0] word_q;
    logic            frame_end;

    assign frame_end = (word_q == cntw'(words_per_frame - 1));
    assign out_last  = valid_q & last_beat & frame_end;

    // Count completed words, wrapping at the frame length.
    always_ff @(posedge clk) begin
      if (reset) begin
        word_q <= '0;
      end else if (beat_fire && last_beat) begin
        word_q <= frame_end ? '0 : word_q + 1'b1;
      end
    end
  end else begin : g_no_frame
    assign out_last = 1'b0;
  end

endmodule

// File: tb/tb_fwft_fifo_unpacker.sv
// Scoreboard bench for fwft_fifo_unpacker: a queue-based FIFO feeds the DUT,
// each accepted word is expanded into expected beats, and a monitor checks the
// stream, the read strobe and the status flags every cycle.
module tb_fwft_fifo_unpacker;

  localparam int unsigned OW    = 8;
  localparam int unsigned RATIO = 4;
  localparam int unsigned IW    = OW * RATIO;
  localparam int unsigned WPF   = 2;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clken = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_read_en;
  logic [IW-1:0] fifo_read_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          busy;

  logic [IW-1:0] fq[$];
  beat_t         exp_q[$];
  int            checks = 0;
  int            passed = 0;
  int            frame_word = 0;
  bit            do_pop = 1'b0;

  fwft_fifo_unpacker #(
    .out_width(OW), .ratio(RATIO), .in_width(IW),
    .words_per_frame(WPF), .cntw(16)
  ) dut (
    .clk(clk), .reset(reset), .clken(clken),
    .fifo_empty(fifo_empty), .fifo_read_en(fifo_read_en), .fifo_read_data(fifo_read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // Monitor and reference model, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    bit            mvalid;
    bit            fire;
    bit            exp_re;
    beat_t         b;
    logic [IW-1:0] w;
    if (reset) begin
      check("read_en_in_reset", 32'(fifo_read_en), 32'd0);
      exp_q.delete();
      frame_word = 0;
      do_pop = 1'b0;
    end else begin
      mvalid = (exp_q.size() > 0);
      fire   = clken && mvalid && out_ready;
      exp_re = clken && !fifo_empty && (!mvalid || (fire && exp_q.size() == 1));
      check("out_valid", 32'(out_valid), 32'(mvalid));
      check("read_en", 32'(fifo_read_en), 32'(exp_re));
      check("busy", 32'(busy), 32'(mvalid || !fifo_empty));
      if (mvalid) begin
        b = exp_q[0];
        check("out_data", 32'(out_data), 32'(b.data));
        check("out_last", 32'(out_last), 32'(b.last));
        if (fire) void'(exp_q.pop_front());
      end else begin
        check("out_last_idle", 32'(out_last), 32'd0);
      end
      if (exp_re) begin
        w = fq[0];
        for (int i = 0; i < int'(RATIO); i++) begin
          b.data = w[i*OW +: OW];
          b.last = (i == int'(RATIO) - 1) && (frame_word == int'(WPF) - 1);
          exp_q.push_back(b);
        end
        frame_word = (frame_word + 1) % int'(WPF);
        do_pop = 1'b1;
      end
    end
  end

  // One clock of stimulus; the bench FIFO is updated just after the edge.
  task automatic cycle(input bit rdy, input bit ce, input bit rst,
                       input bit push, input logic [IW-1:0] w);
    @(posedge clk);
    #1;
    if (do_pop) begin
      void'(fq.pop_front());
      do_pop = 1'b0;
    end
    if (push) fq.push_back(w);
    out_ready = rdy;
    clken     = ce;
    reset     = rst;
    fifo_empty = (fq.size() == 0);
    fifo_read_data = fifo_empty ? IW'($urandom) : fq[0];
  endtask

  initial begin
    int budget;
    // Reset, then one word streamed with the consumer always ready.
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h44332211);
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    // Two queued words stream back to back.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'hDDCCBBAA);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h04030201);
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    // Backpressure mid-word.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h44332211);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    repeat (5) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    // Clock enable low mid-word.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'hA1B2C3D4);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    // Reset in the middle of a word, then a fresh word and frame.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h44332211);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h88776655);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D);
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(2) != 0), ($urandom_range(7) != 0), ($urandom_range(63) == 0),
            (fq.size() < 6) && ($urandom_range(2) == 0), IW'($urandom));
    end
    // Drain everything that is still queued.
    budget = 200;
    while ((fq.size() > 0 || exp_q.size() > 0 || do_pop) && budget > 0) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
      budget--;
    end
    check("drain_complete", 32'(budget > 0), 32'd1);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
